ctrl_determinante: RTL and testbench

//  Sequencer for the determinant ALU. Accepts a start command with matrix size,

---
 rtl/ctrl_determinante_pkg.sv | 36 +++
 rtl/ctrl_determinante_if.sv | 31 +++
 rtl/carga_matriz.sv | 39 +++
 rtl/ctrl_determinante.sv | 123 ++++++++++++
 tb/tb_ctrl_determinante.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_determinante_pkg.sv
// Shared definitions for the determinant-ALU sequencer.
//   DATA_W / MAX_N / MAT_W : element width, largest matrix order, matrix bus width
//   state_e                : sequencer states
//   TAM_*                  : size codes carried on tam_i / sinalizador_o
//   n_of / nn_of           : matrix order and element count for a size code
package det_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAX_N  = 5;
    localparam int unsigned MAT_W  = MAX_N * MAX_N * DATA_W;
    // Wide enough to index MAX_N*MAX_N = 25 elements.
    localparam int unsigned IDX_W  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCarga,
        StCalc,
        StResult
    } state_e;

    localparam logic [1:0] TAM_2X2 = 2'b00;
    localparam logic [1:0] TAM_3X3 = 2'b01;
    localparam logic [1:0] TAM_4X4 = 2'b10;
    localparam logic [1:0] TAM_5X5 = 2'b11;

    function automatic logic [2:0] n_of(input logic [1:0] tam);
        return 3'(tam) + 3'd2;
    endfunction

    function automatic logic [IDX_W-1:0] nn_of(input logic [1:0] tam);
        logic [IDX_W-1:0] n;
        n = IDX_W'(n_of(tam));
        return n * n;
    endfunction

endpackage

// File: rtl/ctrl_determinante_if.sv
// Bundle of command, element stream, ALU and result signals of the sequencer.
//   slave  : the sequencer side (ctrl_determinante)
//   master : the environment side (command source, element source, ALU, result sink)
interface ctrl_determinante_if;

    logic                       start_i;
    logic [1:0]                 tam_i;
    logic                       cancel_i;
    logic [det_pkg::DATA_W-1:0] elem_i;
    logic                       elem_valid_i;
    logic                       elem_ready_o;
    logic [det_pkg::MAT_W-1:0]  matriz_o;
    logic [1:0]                 sinalizador_o;
    logic [det_pkg::DATA_W-1:0] det_i;
    logic [det_pkg::DATA_W-1:0] det_o;
    logic                       det_valid_o;
    logic                       det_ready_i;
    logic                       busy_o;
    logic                       erro_o;

    modport slave (
        input  start_i, tam_i, cancel_i, elem_i, elem_valid_i, det_i, det_ready_i,
        output elem_ready_o, matriz_o, sinalizador_o, det_o, det_valid_o, busy_o, erro_o
    );

    modport master (
        output start_i, tam_i, cancel_i, elem_i, elem_valid_i, det_i, det_ready_i,
        input  elem_ready_o, matriz_o, sinalizador_o, det_o, det_valid_o, busy_o, erro_o
    );

endinterface

// File: rtl/carga_matriz.sv
// Matrix bus register with indexed element writes.
//   clk, rst_n : clock, async active-low reset (clears the bus)
//   clear_i    : synchronous clear of the whole bus (wins over we_i)
//   we_i       : write data_i into element slot idx_i
//   idx_i      : element index, slot k occupies bits [8k+7:8k]
//   data_i     : element value
//   mat_o      : assembled matrix bus
module carga_matriz
    import det_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [MAT_W-1:0]  mat_o
);

    logic [MAT_W-1:0] mat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q <= '0;
        end else if (clear_i) begin
            mat_q <= '0;
        end else if (we_i) begin
            // Index decode; indices beyond the last slot write nothing.
            for (int k = 0; k < int'(MAX_N * MAX_N); k++) begin
                if (idx_i == IDX_W'(k)) begin
                    mat_q[k*DATA_W +: DATA_W] <= data_i;
                end
            end
        end
    end

    assign mat_o = mat_q;

endmodule

// File: rtl/ctrl_determinante.sv
// Sequencer for the determinant ALU: takes a start command with a size code, loads
// N*N row-major elements into the ALU matrix bus, waits WAIT_CYC cycles for the ALU
// to settle, registers its determinant and offers it on a valid/ready output.
//   clk, rst_n : clock, async active-low reset
//   bus        : ctrl_determinante_if.slave (command, elements, ALU, result, status)
// Build option: CTRL_DET_SIZE_CHECK_EN rejects size codes 10/11 with a 1-cycle erro_o
// pulse; without it every size is sequenced and erro_o is tied low.
module ctrl_determinante
    import det_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ctrl_determinante_if.slave   bus
);

    localparam int unsigned  WcntW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WcntW-1:0] WcntLast = WcntW'(WAIT_CYC - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    nn_q;
    logic [WcntW-1:0]    wcnt_q;
    logic [DATA_W-1:0]   det_q;
    logic [1:0]          sinal_q;
    logic                size_ok;
    logic                mat_clear;
    logic                elem_acc;

`ifdef CTRL_DET_SIZE_CHECK_EN
    logic erro_q;
    assign size_ok = !bus.tam_i[1];
`else
    assign size_ok = 1'b1;
`endif

    // cancel_i overrides both the start and any element handshake in flight.
    assign mat_clear = (state_q == StIdle) && bus.start_i && !bus.cancel_i && size_ok;
    assign elem_acc  = (state_q == StCarga) && bus.elem_valid_i && !bus.cancel_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            nn_q    <= '0;
            wcnt_q  <= '0;
            det_q   <= '0;
            sinal_q <= '0;
`ifdef CTRL_DET_SIZE_CHECK_EN
            erro_q  <= 1'b0;
`endif
        end else begin
`ifdef CTRL_DET_SIZE_CHECK_EN
            erro_q <= 1'b0;
`endif
            if (bus.cancel_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.start_i) begin
`ifdef CTRL_DET_SIZE_CHECK_EN
                            if (!size_ok) erro_q <= 1'b1;
                            else
`endif
                            begin
                                state_q <= StCarga;
                                sinal_q <= bus.tam_i;
                                nn_q    <= nn_of(bus.tam_i);
                                idx_q   <= '0;
                            end
                        end
                    end
                    StCarga: begin
                        if (elem_acc) begin
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == nn_q - 1'b1) begin
                                state_q <= StCalc;
                                wcnt_q  <= '0;
                            end
                        end
                    end
                    StCalc: begin
                        if (wcnt_q == WcntLast) begin
                            det_q   <= bus.det_i;
                            state_q <= StResult;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    StResult: begin
                        // A start_i in the handshake cycle is dropped, not queued.
                        if (bus.det_ready_i) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    carga_matriz u_carga_matriz (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (mat_clear),
        .we_i    (elem_acc),
        .idx_i   (idx_q),
        .data_i  (bus.elem_i),
        .mat_o   (bus.matriz_o)
    );

    assign bus.elem_ready_o  = (state_q == StCarga);
    assign bus.det_valid_o   = (state_q == StResult);
    assign bus.busy_o        = (state_q != StIdle);
    assign bus.det_o         = det_q;
    assign bus.sinalizador_o = sinal_q;
`ifdef CTRL_DET_SIZE_CHECK_EN
    assign bus.erro_o        = erro_q;
`else
    assign bus.erro_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_determinante.sv
// Self-checking bench for ctrl_determinante: directed scenarios plus random
// transactions, with a scoreboard queue drained by an independent result monitor.
module tb_ctrl_determinante;
    import det_pkg::*;

    localparam int unsigned WAIT_CYC = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_determinante_if bus ();

    ctrl_determinante #(.WAIT_CYC(WAIT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Determinant ALU stand-in: supports 2x2 and 3x3, returns 0 otherwise.
    int alu_a [25];
    int alu_d;
    always_comb begin
        alu_d = 0;
        for (int k = 0; k < 25; k++) alu_a[k] = int'($signed(bus.matriz_o[k*8 +: 8]));
        case (bus.sinalizador_o)
            2'b00: alu_d = alu_a[0] * alu_a[3] - alu_a[1] * alu_a[2];
            2'b01: alu_d = alu_a[0] * (alu_a[4] * alu_a[8] - alu_a[5] * alu_a[7])
                         - alu_a[1] * (alu_a[3] * alu_a[8] - alu_a[5] * alu_a[6])
                         + alu_a[2] * (alu_a[3] * alu_a[7] - alu_a[4] * alu_a[6]);
            default: alu_d = 0;
        endcase
        bus.det_i = alu_d[7:0];
    end

    typedef struct {
        logic [7:0]       det;
        logic [MAT_W-1:0] mat;
        logic [1:0]       tam;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [MAT_W-1:0] act,
                         input logic [MAT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: determinant by Sarrus / cross product on an N x N grid, wrapped to 8 bits.
    function automatic logic [7:0] ref_det(input int n, input int e [25]);
        int m [3][3];
        int d;
        d = 0;
        if (n == 2 || n == 3) begin
            for (int r = 0; r < n; r++)
                for (int c = 0; c < n; c++) m[r][c] = e[r*n + c];
        end
        if (n == 2) begin
            d = m[0][0] * m[1][1] - m[0][1] * m[1][0];
        end else if (n == 3) begin
            d = m[0][0]*m[1][1]*m[2][2] + m[0][1]*m[1][2]*m[2][0] + m[0][2]*m[1][0]*m[2][1]
              - m[0][2]*m[1][1]*m[2][0] - m[0][0]*m[1][2]*m[2][1] - m[0][1]*m[1][0]*m[2][2];
        end
        return d[7:0];
    endfunction

    function automatic logic [MAT_W-1:0] ref_mat(input int n, input int e [25]);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int k = 0; k < n * n; k++) r[k*8 +: 8] = 8'(e[k]);
        return r;
    endfunction

    // Result monitor: pops on every output handshake, and checks stalled outputs hold.
    logic [7:0] prev_det;
    logic       prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.det_valid_o) check("det_stable", bus.det_o, prev_det);
            if (bus.det_valid_o && bus.det_ready_i) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got result %0h expected none", bus.det_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("det", bus.det_o, mon_e.det);
                    check("matriz", bus.matriz_o, mon_e.mat);
                    check("sinalizador", bus.sinalizador_o, mon_e.tam);
                end
            end
            prev_stall = bus.det_valid_o && !bus.det_ready_i;
            prev_det   = bus.det_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] tam);
        bus.start_i = 1'b1;
        bus.tam_i   = tam;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic send_elem(input int v, input int gap);
        bit done;
        done = 1'b0;
        bus.elem_valid_i = 1'b0;
        repeat (gap) tick();
        bus.elem_i       = 8'(v);
        bus.elem_valid_i = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.elem_ready_o) done = 1'b1;
            tick();
        end
        bus.elem_valid_i = 1'b0;
        if (!done) check("elem_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (bus.det_valid_o) seen = 1'b1;
            else tick();
        end
        if (!seen) check("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish_result();
        tick();
        bus.det_ready_i = 1'b1;
        tick();
        bus.det_ready_i = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] tam, input int e [25]);
        exp_t x;
        x.det = ref_det(int'(tam) + 2, e);
        x.mat = ref_mat(int'(tam) + 2, e);
        x.tam = tam;
        sb_q.push_back(x);
    endtask

    task automatic run_txn(input logic [1:0] tam, input int e [25], input int gap_max,
                           input int hold);
        int n;
        n = int'(tam) + 2;
        start_cmd(tam);
        for (int k = 0; k < n * n; k++) send_elem(e[k], $urandom_range(0, gap_max));
        push_exp(tam, e);
        wait_valid();
        repeat (hold) tick();
        finish_result();
    endtask

    task automatic t1();
        int e [25];
        e = '{default: 0};
        e[0] = 3; e[1] = 1; e[2] = 2; e[3] = 4;
        start_cmd(TAM_2X2);
        for (int k = 0; k < 4; k++) send_elem(e[k], 0);
        push_exp(TAM_2X2, e);
        for (int i = 0; i < int'(WAIT_CYC); i++) begin
            @(negedge clk);
            check("t1_latency_low", bus.det_valid_o, 1'b0);
            tick();
        end
        @(negedge clk);
        check("t1_latency_high", bus.det_valid_o, 1'b1);
        check("t1_matriz_lo", bus.matriz_o[31:0], 32'h04020103);
        check("t1_det", bus.det_o, 8'd10);
        finish_result();
        @(negedge clk);
        check("t1_busy_after", bus.busy_o, 1'b0);
        tick();
    endtask

    initial begin
        int e [25];
        bus.start_i      = 1'b0;
        bus.tam_i        = 2'b00;
        bus.cancel_i     = 1'b0;
        bus.elem_i       = '0;
        bus.elem_valid_i = 1'b0;
        bus.det_ready_i  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_ready", bus.elem_ready_o, 1'b0);
        check("rst_valid", bus.det_valid_o, 1'b0);
        check("rst_det", bus.det_o, '0);
        check("rst_matriz", bus.matriz_o, '0);
        check("rst_erro", bus.erro_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // T1: 2x2 back-to-back with latency check
        t1();

        // T2: 3x3 diagonal with 3-cycle gaps
        e = '{default: 0};
        e[0] = 2; e[4] = 3; e[8] = -1;
        start_cmd(TAM_3X3);
        for (int k = 0; k < 9; k++) send_elem(e[k], 3);
        push_exp(TAM_3X3, e);
        @(negedge clk);
        check("t2_ready_calc", bus.elem_ready_o, 1'b0);
        wait_valid();
        check("t2_ready_result", bus.elem_ready_o, 1'b0);
        check("t2_det", bus.det_o, 8'hFA);
        finish_result();

        // T3: backpressure, start ignored during RESULT and at its handshake
        e = '{default: 0};
        e[0] = 5; e[1] = 2; e[2] = 1; e[3] = 3;
        start_cmd(TAM_2X2);
        for (int k = 0; k < 4; k++) send_elem(e[k], 0);
        push_exp(TAM_2X2, e);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start_i = (i == 2);
            @(negedge clk);
            check("t3_valid_hold", bus.det_valid_o, 1'b1);
            check("t3_det_hold", bus.det_o, 8'd13);
            check("t3_busy", bus.busy_o, 1'b1);
        end
        tick();
        bus.start_i     = 1'b1;
        bus.det_ready_i = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        bus.det_ready_i = 1'b0;
        @(negedge clk);
        check("t3_no_queue_busy", bus.busy_o, 1'b0);
        check("t3_no_queue_ready", bus.elem_ready_o, 1'b0);
        tick();

        // T4: cancel after 2 of 4 elements, with a colliding element handshake
        start_cmd(TAM_2X2);
        send_elem(7, 0);
        send_elem(8, 0);
        bus.elem_i       = 8'd9;
        bus.elem_valid_i = 1'b1;
        bus.cancel_i     = 1'b1;
        tick();
        bus.elem_valid_i = 1'b0;
        bus.cancel_i     = 1'b0;
        @(negedge clk);
        check("t4_busy", bus.busy_o, 1'b0);
        check("t4_ready", bus.elem_ready_o, 1'b0);
        check("t4_matriz_kept", bus.matriz_o[23:0], 24'h000807);
        tick();
        e = '{default: 0};
        e[0] = 1; e[3] = 1;
        run_txn(TAM_2X2, e, 0, 0);

        // T5: async reset in CALC, then T1 again
        e = '{default: 0};
        e[0] = 3; e[1] = 1; e[2] = 2; e[3] = 4;
        start_cmd(TAM_2X2);
        for (int k = 0; k < 4; k++) send_elem(e[k], 0);
        check("t5_in_calc", bus.busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_busy", bus.busy_o, 1'b0);
        check("t5_det", bus.det_o, '0);
        check("t5_matriz", bus.matriz_o, '0);
        check("t5_sinal", bus.sinalizador_o, 2'b00);
        check("t5_valid", bus.det_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        t1();

        // T6: size code 10
`ifdef CTRL_DET_SIZE_CHECK_EN
        start_cmd(TAM_4X4);
        @(negedge clk);
        check("t6_erro_pulse", bus.erro_o, 1'b1);
        check("t6_busy", bus.busy_o, 1'b0);
        check("t6_ready", bus.elem_ready_o, 1'b0);
        tick();
        @(negedge clk);
        check("t6_erro_end", bus.erro_o, 1'b0);
        tick();
`else
        for (int k = 0; k < 25; k++) e[k] = int'($urandom_range(0, 40)) - 20;
        run_txn(TAM_4X4, e, 1, 0);
        check("t6_det_zero", bus.det_o, '0);
`endif

        // Random transactions
        for (int t = 0; t < 12; t++) begin
            logic [1:0] tam;
`ifdef CTRL_DET_SIZE_CHECK_EN
            tam = 2'($urandom_range(0, 1));
`else
            tam = 2'($urandom_range(0, 3));
`endif
            for (int k = 0; k < 25; k++) e[k] = int'($urandom_range(0, 40)) - 20;
            run_txn(tam, e, 2, int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
